// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA polling controller: register-select codes,
// status bit positions and the controller FSM state encoding.
package acia_pkg;

    // ACIA register select values driven on acia_regSel
    localparam logic [1:0] ACIA_REG_DATA = 2'd0;
    localparam logic [1:0] ACIA_REG_STAT = 2'd1;

    // Bit positions inside the ACIA status register
    localparam int ACIA_ST_RDRF = 0;  // receive data register full
    localparam int ACIA_ST_TDRE = 1;  // transmit data register empty

    // Polling controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STAT_RD   = 3'd1,
        ST_STAT_WAIT = 3'd2,
        ST_DECIDE    = 3'd3,
        ST_DATA_RD   = 3'd4,
        ST_DATA_WAIT = 3'd5,
        ST_DATA_WR   = 3'd6
    } state_t;

endpackage : acia_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push and a pop in the same cycle are both taken, also when full;
// a push into an empty FIFO is not bypassed to the head (visible next cycle).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_head;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW:0]      w_rd_next;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign w_rd_next = r_rd_ptr + (AW+1)'(w_pop_ok);
    assign o_head    = r_head;

    // Storage array write port
    // NOTE: the data array has no reset; pointers alone define validity, and a
    // reset term would turn the array into flops with a large reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointer update
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
        end
    end

    // Head register: takes the incoming word when it becomes the new head,
    // otherwise the array entry at the next read pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
        end else if (w_push_ok || w_pop_ok) begin
            if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
                r_head <= i_data;
            end else begin
                r_head <= r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

endmodule : sync_fifo

// File: rtl/acia_poll_ctrl.sv
// Polling controller for the acia UART register port.
// Periodically reads the status register, drains received bytes into an RX
// FIFO and feeds bytes from a TX FIFO whenever the transmitter is empty.
// Optional feature: define ACIA_POLL_DROPCNT_EN to add the drop_cnt output
// (saturating count of RX bytes lost on a full FIFO) and the drop_clr input.
module acia_poll_ctrl
    import acia_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int POLL_DIV   = 64,
    parameter int RD_LAT     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       acia_wr,
    output logic       acia_rd,
    output logic [1:0] acia_regSel,
    output logic [7:0] acia_din,
    input  logic [7:0] acia_dout,
    output logic       busy
`ifdef ACIA_POLL_DROPCNT_EN
    ,
    output logic [7:0] drop_cnt,
    input  logic       drop_clr
`endif
);

    localparam int               CNT_W       = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_DIV - 1);
    localparam logic [1:0]       WAIT_RELOAD = 2'(RD_LAT - 1);

    // FSM and registered ACIA-side outputs
    state_t           r_state;
    logic [CNT_W-1:0] r_poll_cnt;
    logic [1:0]       r_wait;
    logic [1:0]       r_stat_q;
    logic             r_acia_rd;
    logic             r_acia_wr;
    logic [1:0]       r_regsel;
    logic [7:0]       r_din;
    logic             r_busy;

    // FIFO interface
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic [7:0] w_tx_head;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic [7:0] w_rx_head;

    assign tx_ready    = ~w_tx_full;
    assign w_tx_push   = tx_valid & ~w_tx_full;
    assign rx_valid    = ~w_rx_empty;
    assign rx_data     = w_rx_head;
    assign w_rx_pop    = rx_ready & ~w_rx_empty;

    // Write is chosen only when no received byte is pending (RX has priority)
    assign w_tx_pop    = (r_state == ST_DECIDE) & ~r_stat_q[ACIA_ST_RDRF] &
                         r_stat_q[ACIA_ST_TDRE] & ~w_tx_empty;

    // The data byte is pushed on the last wait cycle; a full FIFO rejects it
    // inside sync_fifo while the ACIA read itself has already completed
    assign w_rx_push   = (r_state == ST_DATA_WAIT) & (r_wait == 2'd0);

    assign acia_rd     = r_acia_rd;
    assign acia_wr     = r_acia_wr;
    assign acia_regSel = r_regsel;
    assign acia_din    = r_din;
    assign busy        = r_busy;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_tx_push),
        .i_data  (tx_data),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_data  (acia_dout),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

    // Poll sequencer: strobes are raised on entry to the strobe states so that
    // each one is registered and lasts exactly one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_poll_cnt <= POLL_RELOAD;
            r_wait     <= 2'd0;
            r_stat_q   <= 2'd0;
            r_acia_rd  <= 1'b0;
            r_acia_wr  <= 1'b0;
            r_regsel   <= 2'd0;
            r_din      <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_acia_rd <= 1'b0;
            r_acia_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_poll_cnt == '0) begin
                        r_state   <= ST_STAT_RD;
                        r_acia_rd <= 1'b1;
                        r_regsel  <= ACIA_REG_STAT;
                        r_busy    <= 1'b1;
                    end else begin
                        r_poll_cnt <= r_poll_cnt - CNT_W'(1);
                    end
                end
                ST_STAT_RD: begin
                    r_state <= ST_STAT_WAIT;
                    r_wait  <= WAIT_RELOAD;
                end
                ST_STAT_WAIT: begin
                    if (r_wait == 2'd0) begin
                        r_stat_q[ACIA_ST_RDRF] <= acia_dout[ACIA_ST_RDRF];
                        r_stat_q[ACIA_ST_TDRE] <= acia_dout[ACIA_ST_TDRE];
                        r_state                <= ST_DECIDE;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                ST_DECIDE: begin
                    if (r_stat_q[ACIA_ST_RDRF]) begin
                        r_state   <= ST_DATA_RD;
                        r_acia_rd <= 1'b1;
                        r_regsel  <= ACIA_REG_DATA;
                    end else if (w_tx_pop) begin
                        r_state   <= ST_DATA_WR;
                        r_acia_wr <= 1'b1;
                        r_regsel  <= ACIA_REG_DATA;
                        r_din     <= w_tx_head;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_poll_cnt <= POLL_RELOAD;
                        r_busy     <= 1'b0;
                    end
                end
                ST_DATA_RD: begin
                    r_state <= ST_DATA_WAIT;
                    r_wait  <= WAIT_RELOAD;
                end
                ST_DATA_WAIT: begin
                    if (r_wait == 2'd0) begin
                        // Re-poll at once: more bytes may already be waiting
                        r_state   <= ST_STAT_RD;
                        r_acia_rd <= 1'b1;
                        r_regsel  <= ACIA_REG_STAT;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                ST_DATA_WR: begin
                    r_state   <= ST_STAT_RD;
                    r_acia_rd <= 1'b1;
                    r_regsel  <= ACIA_REG_STAT;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACIA_POLL_DROPCNT_EN
    logic       w_rx_drop;
    logic [7:0] r_drop_cnt;

    // A drop is a push the RX FIFO cannot take (full and not popping)
    assign w_rx_drop = w_rx_push & w_rx_full & ~w_rx_pop;
    assign drop_cnt  = r_drop_cnt;

    // Saturating drop counter; the synchronous clear overrides a coincident drop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= 8'd0;
        end else if (drop_clr) begin
            r_drop_cnt <= 8'd0;
        end else if (w_rx_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end
`endif

endmodule : acia_poll_ctrl

// File: tb/tb_acia_poll_ctrl.sv
// Testbench for acia_poll_ctrl with a behavioural ACIA register model.
// Build with ACIA_POLL_DROPCNT_EN defined to also cover drop_cnt/drop_clr.
module tb_acia_poll_ctrl;
    import acia_pkg::*;

    localparam int FIFO_DEPTH = 16;
    localparam int POLL_DIV   = 64;
    localparam int RD_LAT     = 1;
    localparam int PERIOD     = POLL_DIV + 1 + RD_LAT + 1;

    localparam int EV_STAT = 1;
    localparam int EV_DRD  = 2;
    localparam int EV_WR   = 3;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       acia_wr;
    logic       acia_rd;
    logic [1:0] acia_regSel;
    logic [7:0] acia_din;
    logic [7:0] acia_dout;
    logic       busy;
`ifdef ACIA_POLL_DROPCNT_EN
    logic [7:0] drop_cnt;
    logic       drop_clr;
`endif

    int checks;
    int errors;
    int cyc;
    int rel_cyc;

    // Behavioural ACIA state and observation logs
    logic       m_tdre;
    logic [7:0] m_rx_q[$];
    int         ev_q[$];
    int         stat_cyc_q[$];
    logic [7:0] wr_log[$];
    logic       prev_rd;
    logic       prev_wr;

    acia_poll_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .POLL_DIV   (POLL_DIV),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .acia_wr     (acia_wr),
        .acia_rd     (acia_rd),
        .acia_regSel (acia_regSel),
        .acia_din    (acia_din),
        .acia_dout   (acia_dout),
        .busy        (busy)
`ifdef ACIA_POLL_DROPCNT_EN
        ,
        .drop_cnt    (drop_cnt),
        .drop_clr    (drop_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ACIA model: answers reads, records writes, checks strobe rules
    always @(negedge clk) begin
        if (!reset) begin
            if (acia_rd || acia_wr) begin
                checks++;
                if (acia_rd && acia_wr) begin
                    errors++;
                    $display("FAIL strobe_excl: rd=%0b wr=%0b both high at cycle %0d", acia_rd, acia_wr, cyc);
                end
                if ((acia_rd && prev_rd) || (acia_wr && prev_wr)) begin
                    errors++;
                    $display("FAIL strobe_len: strobe longer than one cycle at cycle %0d", cyc);
                end
            end
            if (acia_rd) begin
                if (acia_regSel == ACIA_REG_STAT) begin
                    ev_q.push_back(EV_STAT);
                    stat_cyc_q.push_back(cyc);
                    acia_dout = {6'd0, m_tdre, (m_rx_q.size() != 0)};
                end else begin
                    ev_q.push_back(EV_DRD);
                    if (m_rx_q.size() != 0) acia_dout = m_rx_q.pop_front();
                    else acia_dout = 8'h00;
                end
            end
            if (acia_wr) begin
                checks++;
                if (acia_regSel !== ACIA_REG_DATA) begin
                    errors++;
                    $display("FAIL wr_regsel: got %0d expected %0d", acia_regSel, ACIA_REG_DATA);
                end
                ev_q.push_back(EV_WR);
                wr_log.push_back(acia_din);
            end
        end
        prev_rd = acia_rd;
        prev_wr = acia_wr;
    end

    // Bounded wait for the controller to return to IDLE
    task automatic wait_busy_low(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_data  = 8'd0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        m_tdre   = 1'b0;
`ifdef ACIA_POLL_DROPCNT_EN
        drop_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_ready, rx_valid, acia_wr, acia_rd, acia_regSel, acia_din, busy, rx_data} !== {1'b1, 22'd0}) begin
            errors++;
            $display("FAIL reset_outputs: tx_ready=%0b rx_valid=%0b wr=%0b rd=%0b regsel=%0d din=%h busy=%0b rx_data=%h expected tx_ready=1 others 0",
                     tx_ready, rx_valid, acia_wr, acia_rd, acia_regSel, acia_din, busy, rx_data);
        end
`ifdef ACIA_POLL_DROPCNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
        end
`endif
        stat_cyc_q.delete();
        ev_q.delete();
        wr_log.delete();
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_poll_period();
        for (int k = 0; k < 4 * PERIOD && stat_cyc_q.size() < 3; k++) @(negedge clk);
        checks++;
        if (stat_cyc_q.size() < 3) begin
            errors++;
            $display("FAIL poll_count: got %0d status reads expected 3", stat_cyc_q.size());
        end else begin
            checks++;
            if (stat_cyc_q[0] - rel_cyc != POLL_DIV) begin
                errors++;
                $display("FAIL poll_first: first status read after %0d cycles expected %0d", stat_cyc_q[0] - rel_cyc, POLL_DIV);
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (stat_cyc_q[i] - stat_cyc_q[i-1] != PERIOD) begin
                    errors++;
                    $display("FAIL poll_period: interval %0d got %0d expected %0d", i, stat_cyc_q[i] - stat_cyc_q[i-1], PERIOD);
                end
            end
        end
        checks++;
        if (wr_log.size() != 0 || tx_ready !== 1'b1 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL poll_quiet: writes=%0d tx_ready=%0b rx_valid=%0b expected 0/1/0", wr_log.size(), tx_ready, rx_valid);
        end
    endtask

    task automatic test_rx_single();
        bit ok;
        wait_busy_low(20, ok);
        ev_q.delete();
        m_rx_q.push_back(8'h41);
        for (int k = 0; k < 2 * PERIOD && ev_q.size() < 3; k++) @(negedge clk);
        wait_busy_low(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rx_idle: busy=%0b expected 0 after draining", busy);
        end
        checks++;
        if (ev_q.size() < 3 || ev_q[0] != EV_STAT || ev_q[1] != EV_DRD || ev_q[2] != EV_STAT) begin
            errors++;
            $display("FAIL rx_sequence: got %0d events first=%0d,%0d,%0d expected %0d,%0d,%0d",
                     ev_q.size(), ev_q[0], ev_q[1], ev_q[2], EV_STAT, EV_DRD, EV_STAT);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h41) begin
            errors++;
            $display("FAIL rx_byte: rx_valid=%0b rx_data=%h expected 1/41", rx_valid, rx_data);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ev_q.size() != 3 || rx_data !== 8'h41) begin
            errors++;
            $display("FAIL rx_hold: events=%0d rx_data=%h expected 3/41", ev_q.size(), rx_data);
        end
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_pop: rx_valid=%0b expected 0", rx_valid);
        end
    endtask

    task automatic test_tx();
        bit ok;
        int n_wr;
        m_tdre = 1'b1;
        wait_busy_low(20, ok);
        ev_q.delete();
        wr_log.delete();
        @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'h55;
        @(posedge clk); #1 tx_data = 8'hAA;
        @(posedge clk); #1 tx_valid = 1'b0;
        for (int k = 0; k < 3 * PERIOD && wr_log.size() < 2; k++) @(negedge clk);
        checks++;
        if (wr_log.size() != 2 || wr_log[0] !== 8'h55 || wr_log[1] !== 8'hAA) begin
            errors++;
            $display("FAIL tx_bytes: got %0d writes %h %h expected 2 writes 55 AA", wr_log.size(), wr_log[0], wr_log[1]);
        end
        n_wr = 0;
        for (int i = 0; i < ev_q.size(); i++) begin
            if (ev_q[i] == EV_WR) begin
                n_wr++;
                checks++;
                if (i == 0 || ev_q[i-1] != EV_STAT) begin
                    errors++;
                    $display("FAIL tx_preceded: write %0d not preceded by status read", n_wr);
                end
            end
        end
        repeat (2 * PERIOD) @(negedge clk);
        checks++;
        if (wr_log.size() != 2 || tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_empty: writes=%0d tx_ready=%0b expected 2/1", wr_log.size(), tx_ready);
        end
    endtask

    task automatic test_priority();
        bit ok;
        logic [7:0] b_tx;
        logic [7:0] b_rx;
        int i_rd;
        int i_wr;
        b_tx = 8'($urandom);
        b_rx = 8'($urandom);
        wait_busy_low(20, ok);
        ev_q.delete();
        wr_log.delete();
        @(posedge clk); #1 tx_valid = 1'b1; tx_data = b_tx;
        m_rx_q.push_back(b_rx);
        @(posedge clk); #1 tx_valid = 1'b0;
        for (int k = 0; k < 2 * PERIOD && wr_log.size() < 1; k++) @(negedge clk);
        i_rd = -1;
        i_wr = -1;
        for (int i = ev_q.size() - 1; i >= 0; i--) begin
            if (ev_q[i] == EV_DRD) i_rd = i;
            if (ev_q[i] == EV_WR)  i_wr = i;
        end
        checks++;
        if (i_rd < 0 || i_wr < 0 || i_rd > i_wr) begin
            errors++;
            $display("FAIL prio_order: data read at event %0d write at event %0d expected read first", i_rd, i_wr);
        end
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== b_tx) begin
            errors++;
            $display("FAIL prio_tx: got %0d writes first=%h expected 1 write %h", wr_log.size(), wr_log[0], b_tx);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== b_rx) begin
            errors++;
            $display("FAIL prio_rx: rx_valid=%0b rx_data=%h expected 1/%h", rx_valid, rx_data, b_rx);
        end
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] exp_b[FIFO_DEPTH + 1];
        int n;
        wait_busy_low(20, ok);
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            exp_b[i] = 8'($urandom);
            m_rx_q.push_back(exp_b[i]);
        end
        for (int k = 0; k < 40 * FIFO_DEPTH && (m_rx_q.size() != 0 || busy); k++) @(negedge clk);
        checks++;
        if (m_rx_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drain: %0d bytes left busy=%0b expected 0/0", m_rx_q.size(), busy);
        end
`ifdef ACIA_POLL_DROPCNT_EN
        checks++;
        if (drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt);
        end
`endif
        @(posedge clk); #1 rx_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 2 * FIFO_DEPTH; k++) begin
            @(negedge clk);
            if (!rx_valid) break;
            checks++;
            if (rx_data !== exp_b[n]) begin
                errors++;
                $display("FAIL ovf_data: entry %0d got %h expected %h", n, rx_data, exp_b[n]);
            end
            n++;
        end
        @(posedge clk); #1 rx_ready = 1'b0;
        checks++;
        if (n != FIFO_DEPTH) begin
            errors++;
            $display("FAIL ovf_count: retained %0d bytes expected %0d", n, FIFO_DEPTH);
        end
`ifdef ACIA_POLL_DROPCNT_EN
        @(posedge clk); #1 drop_clr = 1'b1;
        @(posedge clk); #1 drop_clr = 1'b0;
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL drop_clr: got %0d expected 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_random();
        localparam int N = 8;
        logic [7:0] tx_b[N];
        logic [7:0] rx_b[N];
        int tx_sent;
        int rx_inj;
        int rx_got;
        for (int i = 0; i < N; i++) begin
            tx_b[i] = 8'($urandom);
            rx_b[i] = 8'($urandom);
        end
        tx_sent = 0;
        rx_inj  = 0;
        rx_got  = 0;
        wr_log.delete();
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #1;
            if (tx_sent == N && rx_got == N && wr_log.size() == N) break;
            // tx_ready is stable until the next edge, so a transfer is certain here
            if (tx_sent < N && tx_ready && $urandom_range(0, 3) == 0) begin
                tx_valid = 1'b1;
                tx_data  = tx_b[tx_sent];
                tx_sent++;
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'($urandom);
            end
            if (rx_inj < N && $urandom_range(0, 19) == 0) begin
                m_rx_q.push_back(rx_b[rx_inj]);
                rx_inj++;
            end
            rx_ready = 1'($urandom_range(0, 1));
            if (rx_ready && rx_valid) begin
                checks++;
                if (rx_got >= N || rx_data !== rx_b[rx_got]) begin
                    errors++;
                    $display("FAIL rand_rx: byte %0d got %h expected %h", rx_got, rx_data, rx_b[rx_got % N]);
                end
                rx_got++;
            end
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        checks++;
        if (tx_sent != N || rx_got != N || wr_log.size() != N) begin
            errors++;
            $display("FAIL rand_done: tx_sent=%0d rx_got=%0d writes=%0d expected %0d each", tx_sent, rx_got, wr_log.size(), N);
        end
        for (int i = 0; i < N && i < wr_log.size(); i++) begin
            checks++;
            if (wr_log[i] !== tx_b[i]) begin
                errors++;
                $display("FAIL rand_tx: write %0d got %h expected %h", i, wr_log[i], tx_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        m_tdre = 1'b0;
        wait_busy_low(20, ok);
        @(posedge clk); #1 tx_valid = 1'b1; tx_data = 8'($urandom);
        @(posedge clk); #1 tx_valid = 1'b0;
        m_rx_q.push_back(8'($urandom));
        seen = 1'b0;
        for (int k = 0; k < 2 * PERIOD; k++) begin
            @(negedge clk);
            if (acia_rd && acia_regSel == ACIA_REG_DATA) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_setup: no data read within %0d cycles", 2 * PERIOD);
        end
        @(posedge clk); #1 reset = 1'b1;
        #1;
        checks++;
        if ({tx_ready, rx_valid, acia_wr, acia_rd, acia_regSel, acia_din, busy, rx_data} !== {1'b1, 22'd0}) begin
            errors++;
            $display("FAIL rst_mid_outputs: tx_ready=%0b rx_valid=%0b wr=%0b rd=%0b regsel=%0d din=%h busy=%0b rx_data=%h expected tx_ready=1 others 0",
                     tx_ready, rx_valid, acia_wr, acia_rd, acia_regSel, acia_din, busy, rx_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (acia_rd !== 1'b0 || acia_wr !== 1'b0 || busy !== 1'b0 || rx_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_quiet: cycle %0d rd=%0b wr=%0b busy=%0b rx_valid=%0b expected all 0", k, acia_rd, acia_wr, busy, rx_valid);
            end
        end
        m_tdre = 1'b1;
        wr_log.delete();
        repeat (2 * PERIOD) @(negedge clk);
        checks++;
        if (wr_log.size() != 0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fifos: writes=%0d rx_valid=%0b expected 0/0", wr_log.size(), rx_valid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        acia_dout = 8'h00;
        prev_rd   = 1'b0;
        prev_wr   = 1'b0;
        test_reset();
        test_poll_period();
        test_rx_single();
        test_tx();
        test_priority();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_acia_poll_ctrl
